mmio_timer_bank: RTL
====================

Name: mmio_timer_bank

Overview:
- Memory-mapped bank of N_CH independent 32-bit reload timers on the CPU load/store peripheral bus.
- Successor to the single-timer TH/TL/TCON peripheral. Adds parametrised channel count, a per-channel prescaler, one-shot mode, write-1-to-clear interrupt status and a global status/clear register.
- Drives one combined interrupt request to the CPU. The request is masked while the CPU runs in kernel mode (PC_31=1).

Parameters:
- N_CH, 2, number of timer channels (1..8).
- BASE_ADDR, 32'h40000100, byte address of channel 0 register block; 16-byte aligned.
- CNT_W, 32, width of TH/TL counters (8..32).
- PRESC_W, 8, width of the prescaler compare register.

Ports:
- sysclk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd  in  1  bus read strobe.
- wr  in  1  bus write strobe.
- addr  in  32  byte address; must be word-aligned.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational.
- irqout  out  1  combined interrupt request.
- PC_31  in  1  CPU kernel-mode bit; 1 masks irqout.

Behaviour:
- Address map, channel c at BASE_ADDR + 16*c:
  - +0x0 TH: reload value, CNT_W bits, R/W.
  - +0x4 TL: count value, R/W.
  - +0x8 TCON: bit0 EN, bit1 IE, bit2 ST, bit3 ONESHOT.
    - EN, IE, ONESHOT are R/W.
    - ST is read; writing 1 clears it, writing 0 leaves it unchanged.
  - +0xC PRESC: PRESC_W bits, R/W.
- Global register at BASE_ADDR + 16*N_CH:
  - GSTAT: bits[N_CH-1:0] mirror every channel's ST.
  - Writing 1 to a bit clears that channel's ST.
- Any other address, or a misaligned address: reads return 0, writes are ignored.
- Unused high bits read as 0.
- rdata = 0 whenever rd=0. Read has zero latency; there are no read side effects.
- Reset (reset=0, asynchronous): all TH, TL, TCON, PRESC and prescaler counters clear to 0; irqout=0 immediately.
- Prescaler:
  - Internal counter pc per channel.
  - While EN=1: if pc==PRESC, then tick=1 and pc<=0; else pc<=pc+1.
  - PRESC=0 gives a tick every cycle.
  - While EN=0, pc is held at 0.
  - A write to PRESC also clears pc.
- Count, on tick:
  - If TL == all-ones: overflow. TL<=TH and ST<=1. If ONESHOT=1, EN<=0 in the same cycle.
  - Otherwise TL<=TL+1, wrapping modulo 2^CNT_W.
- ST sets on overflow regardless of IE. IE only gates the interrupt.
- irqout = !PC_31 & OR over channels of (ST & IE). Combinational from registers: one cycle after the overflow edge.
- Simultaneous events, same cycle:
  - Bus write to TL vs tick: the write wins; no increment.
  - Bus write to TCON vs overflow: EN/IE/ONESHOT take the written values. ST set by the overflow wins over a W1C clear, so no event is lost.
  - GSTAT W1C vs overflow on the same channel: the overflow wins.
  - Write to TH during overflow: TL reloads from the old TH.
- Reset asserted mid-count: everything clears asynchronously. Counting resumes only after software sets EN.
- rd and wr asserted together: the write applies and the read returns pre-write register values.

Decomposition:
- Package mmio_timer_pkg:
  - Register offsets: OFF_TH=0x0, OFF_TL=0x4, OFF_TCON=0x8, OFF_PRESC=0xC, CH_STRIDE=16.
  - TCON bit indices: EN=0, IE=1, ST=2, ONESHOT=3.
- Sub-module timer_channel, instantiated N_CH times by generate:
  - Holds TH/TL/TCON/PRESC and the prescaler.
  - Inputs: decoded per-register write enables, wdata, W1C clear.
  - Outputs: register values and ST&IE.
- Top level: address decode, read mux, GSTAT, irqout.

Test Plan:
- Reset then read every register of every channel -> all 0; irqout=0; unmapped address BASE_ADDR+16*N_CH+4 reads 0.
- Ch0 TH=0xFFFFFFF0, TL=0xFFFFFFFE, PRESC=0, TCON=0x3 (EN|IE) -> TL=0xFFFFFFFF after 1 cycle; TL=0xFFFFFFF0 and ST=1 after 2 cycles; irqout=1 on the following cycle with PC_31=0; PC_31=1 forces irqout=0.
- Ch1 PRESC=3, TL=0, EN=1 -> TL increments once every 4 cycles (1 at cycle 4, 2 at cycle 8); clear EN -> TL frozen and prescaler reset.
- Ch0 ONESHOT|EN|IE with TL=all-ones, TH=5 -> after 1 tick TL=5, ST=1, EN=0; TL stays 5 thereafter.
- W1C: ST=1 on ch0 and ch1, write GSTAT=0b01 -> ch0 ST=0, ch1 ST=1. Write TCON of ch1 with bit2=1 in the same cycle as a new ch1 overflow -> ST remains 1.
- Bus write TL=0x100 in the same cycle as a tick -> TL reads 0x100, not 0x101; rd+wr to TH with wdata=7 -> rdata shows old TH, next read shows 7.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// Shared register map and TCON bit layout for the MMIO timer bank.
// Imported by the channel and the bus-facing top.
package mmio_timer_pkg;

    localparam logic [3:0] OFF_TH    = 4'h0;
    localparam logic [3:0] OFF_TL    = 4'h4;
    localparam logic [3:0] OFF_TCON  = 4'h8;
    localparam logic [3:0] OFF_PRESC = 4'hC;
    localparam int         CH_STRIDE = 16;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;
    localparam int TCON_OS = 3;

endpackage

// File: rtl/timer_channel.sv
// One reload timer: TH/TL/TCON/PRESC registers plus prescaler.
// Overflow beats any same-cycle W1C clear so no event is lost.
module timer_channel
    import mmio_timer_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               i_we_th,
    input  logic               i_we_tl,
    input  logic               i_we_tcon,
    input  logic               i_we_presc,
    input  logic               i_clr_st,
    input  logic [31:0]        i_wdata,
    output logic [CNT_W-1:0]   o_th,
    output logic [CNT_W-1:0]   o_tl,
    output logic [3:0]         o_tcon,
    output logic [PRESC_W-1:0] o_presc,
    output logic               o_irq
);

    logic [CNT_W-1:0]   r_th;
    logic [CNT_W-1:0]   r_tl;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_pc;
    logic               r_en;
    logic               r_ie;
    logic               r_st;
    logic               r_os;

    logic w_tick;
    logic w_ovf;
    logic w_clr;
    logic w_unused;

    assign w_tick   = r_en && (r_pc == r_presc);
    assign w_ovf    = w_tick && (r_tl == '1);
    assign w_clr    = i_clr_st || (i_we_tcon && i_wdata[TCON_ST]);
    assign w_unused = &{1'b0, i_wdata};

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_th    <= '0;
            r_tl    <= '0;
            r_presc <= '0;
            r_pc    <= '0;
            r_en    <= 1'b0;
            r_ie    <= 1'b0;
            r_st    <= 1'b0;
            r_os    <= 1'b0;
        end else begin
            if (i_we_th)
                r_th <= i_wdata[CNT_W-1:0];

            // Reload uses the TH value held before any same-cycle write.
            if (i_we_tl)
                r_tl <= i_wdata[CNT_W-1:0];
            else if (w_tick)
                r_tl <= w_ovf ? r_th : r_tl + CNT_W'(1);

            if (i_we_tcon) begin
                r_en <= i_wdata[TCON_EN];
                r_ie <= i_wdata[TCON_IE];
                r_os <= i_wdata[TCON_OS];
            end else if (w_ovf && r_os) begin
                r_en <= 1'b0;
            end

            if (w_ovf)
                r_st <= 1'b1;
            else if (w_clr)
                r_st <= 1'b0;

            if (i_we_presc)
                r_presc <= i_wdata[PRESC_W-1:0];

            if (i_we_presc || !r_en || w_tick)
                r_pc <= '0;
            else
                r_pc <= r_pc + PRESC_W'(1);
        end
    end

    assign o_th    = r_th;
    assign o_tl    = r_tl;
    assign o_tcon  = {r_os, r_st, r_ie, r_en};
    assign o_presc = r_presc;
    assign o_irq   = r_st & r_ie;

endmodule

// File: rtl/mmio_timer_bank.sv
// Bus-facing bank of N_CH reload timers: decode, read mux, GSTAT, irq.
// Reads are combinational and side-effect free.
module mmio_timer_bank
    import mmio_timer_pkg::*;
#(
    parameter int          N_CH      = 2,
    parameter logic [31:0] BASE_ADDR = 32'h40000100,
    parameter int          CNT_W     = 32,
    parameter int          PRESC_W   = 8
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irqout,
    input  logic        PC_31
);

    localparam logic [31:0] CH_SPAN = 32'(CH_STRIDE * N_CH);

    logic [31:0]      w_off;
    logic             w_ok;
    logic             w_hit_ch;
    logic             w_hit_gs;
    logic [2:0]       w_ch;
    logic             w_is_th;
    logic             w_is_tl;
    logic             w_is_tcon;
    logic             w_is_presc;
    logic [N_CH-1:0]  w_gclr;
    logic [N_CH-1:0]  w_st;
    logic [N_CH-1:0]  w_irq;

    logic [CNT_W-1:0]   w_th    [N_CH];
    logic [CNT_W-1:0]   w_tl    [N_CH];
    logic [3:0]         w_tcon  [N_CH];
    logic [PRESC_W-1:0] w_presc [N_CH];

    assign w_off      = addr - BASE_ADDR;
    assign w_ok       = (addr[1:0] == 2'b00) && (addr >= BASE_ADDR);
    assign w_hit_ch   = w_ok && (w_off < CH_SPAN);
    assign w_hit_gs   = w_ok && (w_off == CH_SPAN);
    assign w_ch       = w_off[6:4];
    assign w_is_th    = (w_off[3:0] == OFF_TH);
    assign w_is_tl    = (w_off[3:0] == OFF_TL);
    assign w_is_tcon  = (w_off[3:0] == OFF_TCON);
    assign w_is_presc = (w_off[3:0] == OFF_PRESC);
    assign w_gclr     = (wr && w_hit_gs) ? wdata[N_CH-1:0] : '0;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic w_sel;
        assign w_sel = wr && w_hit_ch && (w_ch == 3'(c));

        timer_channel #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W)
        ) u_ch (
            .sysclk     (sysclk),
            .reset      (reset),
            .i_we_th    (w_sel && w_is_th),
            .i_we_tl    (w_sel && w_is_tl),
            .i_we_tcon  (w_sel && w_is_tcon),
            .i_we_presc (w_sel && w_is_presc),
            .i_clr_st   (w_gclr[c]),
            .i_wdata    (wdata),
            .o_th       (w_th[c]),
            .o_tl       (w_tl[c]),
            .o_tcon     (w_tcon[c]),
            .o_presc    (w_presc[c]),
            .o_irq      (w_irq[c])
        );

        assign w_st[c] = w_tcon[c][TCON_ST];
    end

    always_comb begin
        rdata = '0;
        if (rd && w_hit_ch) begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_ch == 3'(c)) begin
                    unique case (1'b1)
                        w_is_th:    rdata = 32'(w_th[c]);
                        w_is_tl:    rdata = 32'(w_tl[c]);
                        w_is_tcon:  rdata = 32'(w_tcon[c]);
                        w_is_presc: rdata = 32'(w_presc[c]);
                        default:    rdata = '0;
                    endcase
                end
            end
        end else if (rd && w_hit_gs) begin
            rdata = 32'(w_st);
        end
    end

    assign irqout = !PC_31 && (|w_irq);

endmodule
